// File: rtl/rv32i_types.sv
// Shared rename types: physical-register index and the free-list pointer
// (low bits index the queue, MSB is the wrap bit).
package rv32i_types;

    localparam int PREG_COUNT_DEFAULT = 64;
    localparam int AREG_COUNT_DEFAULT = 32;
    localparam int PREG_IDX_WIDTH     = $clog2(PREG_COUNT_DEFAULT);
    localparam int FL_DEPTH_DEFAULT   = PREG_COUNT_DEFAULT - AREG_COUNT_DEFAULT;
    localparam int FL_PTR_WIDTH       = $clog2(FL_DEPTH_DEFAULT) + 1;

    typedef logic [PREG_IDX_WIDTH-1:0] free_list_entry_t;
    typedef logic [FL_PTR_WIDTH-1:0]   fl_ptr_t;

endpackage

// File: rtl/free_list.sv
// Circular free list of physical registers with a speculative and an architectural head.
// Optional FREELIST_BYPASS_EN: an enqueue into an empty list is visible the same cycle.
module free_list
    import rv32i_types::*;
#(
    parameter int PREG_COUNT = PREG_COUNT_DEFAULT,
    parameter int AREG_COUNT = AREG_COUNT_DEFAULT,
    parameter int FL_DEPTH   = PREG_COUNT - AREG_COUNT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enqueue_freelist,
    input  free_list_entry_t freed_preg,
    output logic             freelist_full,
    input  logic             dequeue_freelist,
    output free_list_entry_t free_preg,
    output logic             freelist_empty,
    input  logic             commit_alloc,
    input  logic             branch_flush
);

    localparam int IDX_W = $clog2(FL_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;

    // Increment modulo 2*FL_DEPTH: at the last slot, clear the index and toggle the wrap bit.
    function automatic ptr_t ptr_inc(input ptr_t p);
        if (p[IDX_W-1:0] == IDX_W'(FL_DEPTH - 1)) begin
            return {~p[PTR_W-1], {IDX_W{1'b0}}};
        end
        return p + PTR_W'(1);
    endfunction

    function automatic ptr_t ptr_count(input ptr_t t, input ptr_t h);
        if (t[PTR_W-1] == h[PTR_W-1]) begin
            return PTR_W'(t[IDX_W-1:0]) - PTR_W'(h[IDX_W-1:0]);
        end
        return PTR_W'(FL_DEPTH) - PTR_W'(h[IDX_W-1:0]) + PTR_W'(t[IDX_W-1:0]);
    endfunction

    free_list_entry_t mem [FL_DEPTH];
    ptr_t spec_head;
    ptr_t arch_head;
    ptr_t tail;

    ptr_t count;
    ptr_t spec_head_next;
    ptr_t arch_head_next;
    ptr_t tail_next;
    logic empty_reg;
    logic bypass;
    logic do_enq;
    logic do_deq;

    // Handshakes: enqueue_freelist is a valid accepted only while !freelist_full, and
    // dequeue_freelist is a ready that takes free_preg only while !freelist_empty;
    // a request that is not accepted is dropped, never held over.
    assign count         = ptr_count(tail, spec_head);
    assign empty_reg     = (count == '0);
    assign freelist_full = (count == PTR_W'(FL_DEPTH));

`ifdef FREELIST_BYPASS_EN
    assign bypass = empty_reg && enqueue_freelist && !branch_flush;
`else
    assign bypass = 1'b0;
`endif

    assign freelist_empty = empty_reg && !bypass;
    assign free_preg      = bypass ? freed_preg : mem[spec_head[IDX_W-1:0]];

    always_comb begin
        do_enq         = enqueue_freelist && !freelist_full;
        do_deq         = dequeue_freelist && !freelist_empty;
        tail_next      = do_enq ? ptr_inc(tail) : tail;
        arch_head_next = arch_head;
        if (commit_alloc && (arch_head != tail)) begin
            arch_head_next = ptr_inc(arch_head);
        end
        // Flush recovers to the post-commit architectural head and drops any dequeue.
        if (branch_flush) begin
            spec_head_next = arch_head_next;
        end else if (do_deq) begin
            spec_head_next = ptr_inc(spec_head);
        end else begin
            spec_head_next = spec_head;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                mem[i] <= free_list_entry_t'(AREG_COUNT + i);
            end
            spec_head <= '0;
            arch_head <= '0;
            tail      <= {1'b1, {IDX_W{1'b0}}};
        end else begin
            if (do_enq) begin
                mem[tail[IDX_W-1:0]] <= freed_preg;
            end
            tail      <= tail_next;
            spec_head <= spec_head_next;
            arch_head <= arch_head_next;
        end
    end

endmodule

// File: tb/tb_free_list.sv
// Directed scoreboard bench for free_list; the driver queues the expected outputs
// of each checked cycle and a monitor compares them on the falling edge.
module tb_free_list;

`ifdef FREELIST_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       enqueue_freelist;
  logic [5:0] freed_preg;
  logic       freelist_full;
  logic       dequeue_freelist;
  logic [5:0] free_preg;
  logic       freelist_empty;
  logic       commit_alloc;
  logic       branch_flush;

  logic [8:0] exp_q[$];
  int         tag_q[$];
  logic       chk_en;
  int         step_no;
  int         n_checks;
  int         n_pass;
  logic [8:0] exp_e;
  int         exp_tag;

  always #5 clk = ~clk;

  free_list dut (
    .clk              (clk),
    .rst              (rst),
    .enqueue_freelist (enqueue_freelist),
    .freed_preg       (freed_preg),
    .freelist_full    (freelist_full),
    .dequeue_freelist (dequeue_freelist),
    .free_preg        (free_preg),
    .freelist_empty   (freelist_empty),
    .commit_alloc     (commit_alloc),
    .branch_flush     (branch_flush)
  );

  task automatic cmp(input string what, input int t, input logic [5:0] act, input logic [5:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s step %0d: got %0d, expected %0d", what, t, act, req);
  endtask

  // Drive one cycle of inputs just after the rising edge.
  task automatic drive(input bit r, input bit enq, input logic [5:0] fp,
                       input bit deq, input bit cm, input bit fl);
    @(posedge clk);
    #1;
    rst              = r;
    enqueue_freelist = enq;
    freed_preg       = fp;
    dequeue_freelist = deq;
    commit_alloc     = cm;
    branch_flush     = fl;
    chk_en           = 1'b0;
    step_no++;
  endtask

  task automatic expect_out(input bit full, input bit empty, input bit cp, input logic [5:0] preg);
    exp_q.push_back({cp, preg, full, empty});
    tag_q.push_back(step_no);
    chk_en = 1'b1;
  endtask

  task automatic do_reset();
    drive(1, 0, 6'd0, 0, 0, 0);
    drive(1, 0, 6'd0, 0, 0, 0);
  endtask

  // Monitor: pop and compare whenever the driver flags a checked cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL scoreboard_underflow step %0d: got empty queue, expected an entry", step_no);
        end else begin
          exp_e   = exp_q.pop_front();
          exp_tag = tag_q.pop_front();
          cmp("freelist_full", exp_tag, {5'd0, freelist_full}, {5'd0, exp_e[1]});
          cmp("freelist_empty", exp_tag, {5'd0, freelist_empty}, {5'd0, exp_e[0]});
          if (exp_e[8]) cmp("free_preg", exp_tag, free_preg, exp_e[7:2]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; enqueue_freelist = 1'b0; freed_preg = '0; dequeue_freelist = 1'b0;
    commit_alloc = 1'b0; branch_flush = 1'b0; chk_en = 1'b0;
    step_no = 0; n_checks = 0; n_pass = 0;

    // Reset state, enqueue while full, drain 32..63, dequeue while empty, refill.
    do_reset();
    drive(0, 0, 6'd0, 0, 0, 0); expect_out(1, 0, 1, 6'd32);
    drive(0, 1, 6'd5, 0, 0, 0); expect_out(1, 0, 1, 6'd32);
    for (int i = 0; i < 32; i++) begin
      drive(0, 0, 6'd0, 1, 0, 0); expect_out(i == 0, 0, 1, 6'(32 + i));
    end
    drive(0, 0, 6'd0, 0, 0, 0); expect_out(0, 1, 0, 6'd0);
    drive(0, 0, 6'd0, 1, 0, 0); expect_out(0, 1, 0, 6'd0);
    drive(0, 1, 6'd10, 0, 0, 0); expect_out(0, !BYP, BYP, 6'd10);
    drive(0, 0, 6'd0, 0, 0, 0); expect_out(0, 0, 1, 6'd10);

    // Reset asserted mid-operation wins over a dequeue.
    drive(1, 0, 6'd0, 1, 0, 0);
    drive(0, 0, 6'd0, 0, 0, 0); expect_out(1, 0, 1, 6'd32);

    // Commit then free: 5 lands behind 33..63.
    do_reset();
    drive(0, 0, 6'd0, 1, 0, 0); expect_out(1, 0, 1, 6'd32);
    drive(0, 0, 6'd0, 0, 1, 0); expect_out(0, 0, 1, 6'd33);
    drive(0, 1, 6'd5, 0, 0, 0); expect_out(0, 0, 1, 6'd33);
    drive(0, 0, 6'd0, 0, 0, 0); expect_out(1, 0, 1, 6'd33);
    for (int i = 0; i < 31; i++) begin
      drive(0, 0, 6'd0, 1, 0, 0); expect_out(i == 0, 0, 1, 6'(33 + i));
    end
    drive(0, 0, 6'd0, 1, 0, 0); expect_out(0, 0, 1, 6'd5);
    drive(0, 0, 6'd0, 0, 0, 0); expect_out(0, 1, 0, 6'd0);

    // Flush after one commit: head returns to 33 with 31 entries.
    do_reset();
    drive(0, 0, 6'd0, 1, 0, 0); expect_out(1, 0, 1, 6'd32);
    drive(0, 0, 6'd0, 1, 0, 0); expect_out(0, 0, 1, 6'd33);
    drive(0, 0, 6'd0, 1, 0, 0); expect_out(0, 0, 1, 6'd34);
    drive(0, 0, 6'd0, 0, 1, 0); expect_out(0, 0, 1, 6'd35);
    drive(0, 0, 6'd0, 0, 0, 1); expect_out(0, 0, 1, 6'd35);
    drive(0, 0, 6'd0, 0, 0, 0); expect_out(0, 0, 1, 6'd33);
    for (int i = 0; i < 31; i++) begin
      drive(0, 0, 6'd0, 1, 0, 0); expect_out(0, 0, 1, 6'(33 + i));
    end
    drive(0, 0, 6'd0, 0, 0, 0); expect_out(0, 1, 0, 6'd0);

    // Flush with same-cycle commit, enqueue of 7 and a dropped dequeue.
    do_reset();
    drive(0, 0, 6'd0, 1, 0, 0); expect_out(1, 0, 1, 6'd32);
    drive(0, 0, 6'd0, 1, 1, 0); expect_out(0, 0, 1, 6'd33);
    drive(0, 0, 6'd0, 1, 0, 0); expect_out(0, 0, 1, 6'd34);
    drive(0, 1, 6'd7, 1, 1, 1); expect_out(0, 0, 1, 6'd35);
    drive(0, 0, 6'd0, 0, 0, 0); expect_out(0, 0, 1, 6'd34);
    for (int i = 0; i < 31; i++) begin
      drive(0, 0, 6'd0, 1, 0, 0); expect_out(0, 0, 1, (i < 30) ? 6'(34 + i) : 6'd7);
    end
    drive(0, 0, 6'd0, 0, 0, 0); expect_out(0, 1, 0, 6'd0);

    // Enqueue and dequeue together while empty.
    do_reset();
    for (int i = 0; i < 32; i++) drive(0, 0, 6'd0, 1, 0, 0);
    drive(0, 1, 6'd9, 1, 0, 0); expect_out(0, !BYP, BYP, 6'd9);
    drive(0, 0, 6'd0, 0, 0, 0); expect_out(0, BYP, !BYP, 6'd9);

    drive(0, 0, 6'd0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    cmp("scoreboard_leftover", step_no, 6'(exp_q.size()), 6'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
